// File: rtl/aes256_pkg.sv
// Shared types for the AES-256 ciphertext output path.
// Block width, block type and output-stage state encoding.
package aes256_pkg;

  localparam int AES_BLK_W = 128;

  typedef logic [AES_BLK_W-1:0] aes_blk_t;

  typedef enum logic {
    SER_IDLE,
    SER_STREAM
  } ser_state_t;

  function automatic int words_per_blk(input int w);
    return AES_BLK_W / w;
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Block FIFO for finished ciphertext blocks.
// Power-of-two depth, so pointers wrap naturally.
module aes_blk_fifo
  import aes256_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  aes_blk_t                   i_data,
  output aes_blk_t                   o_head,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  aes_blk_t        r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [LW-1:0]   r_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage is data-only; validity is tracked by the level.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_level = r_level;
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);

endmodule

// File: rtl/aes256_out_serializer.sv
// Ciphertext output stage: buffers finished blocks and
// streams each as OUT_W-bit words on a req/ready handshake.
module aes256_out_serializer
  import aes256_pkg::*;
#(
  parameter int OUT_W     = 8,
  parameter int DEPTH     = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pi_blk_valid,
  input  aes_blk_t                   pi_blk_data,
  output logic                       po_blk_ready,
  input  logic                       pi_next_val_req,
  output logic                       po_next_val_ready,
  output logic [OUT_W-1:0]           po_data,
  output logic                       po_last,
  output logic [$clog2(DEPTH+1)-1:0] po_fifo_level,
  output logic                       po_overflow,
  input  logic                       pi_clr_overflow
);

  localparam int WORDS = words_per_blk(OUT_W);
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  if (!(OUT_W == 8 || OUT_W == 16 || OUT_W == 32 ||
        OUT_W == 64 || OUT_W == 128)) begin : g_bad_w
    $error("aes256_out_serializer: illegal OUT_W");
  end

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_d
    $error("aes256_out_serializer: illegal DEPTH");
  end

  ser_state_t    r_state;
  logic [IW-1:0] r_idx;
  logic          r_ovf;

  aes_blk_t      w_head;
  logic [LW-1:0] w_level;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_xfer;
  logic          w_pop_last;
  logic [IW-1:0] w_sel;

  aes_blk_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop_last),
    .i_data  (pi_blk_data),
    .o_head  (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign po_next_val_ready = (r_state == SER_STREAM);
  assign po_last    = po_next_val_ready && (r_idx == LAST_IDX);
  assign w_xfer     = po_next_val_ready && pi_next_val_req;
  assign w_pop_last = w_xfer && po_last;

  // Head retiring this cycle frees a slot for the incoming block.
  assign po_blk_ready = !w_full || w_pop_last;
  assign w_push       = pi_blk_valid && po_blk_ready;

  assign w_sel   = MSB_FIRST ? (LAST_IDX - r_idx) : r_idx;
  assign po_data = w_empty ? '0
                 : w_head[int'(w_sel) * OUT_W +: OUT_W];

  assign po_fifo_level = w_level;
  assign po_overflow   = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SER_IDLE;
      r_idx   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        SER_IDLE: begin
          if (w_push) r_state <= SER_STREAM;
        end
        SER_STREAM: begin
          if (w_pop_last && w_level == LW'(1) && !w_push)
            r_state <= SER_IDLE;
        end
        default: r_state <= SER_IDLE;
      endcase

      if (w_xfer) r_idx <= po_last ? '0 : r_idx + 1'b1;

      if (pi_blk_valid && !po_blk_ready) r_ovf <= 1'b1;
      else if (pi_clr_overflow)          r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes256_out_serializer.sv
// Bench for the ciphertext output serializer: known-answer
// tables, hand-written corner sequences and a queue-based model.
module tb_aes256_out_serializer;
  import aes256_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } vec8_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } vec32_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       v8 = 1'b0, rq8 = 1'b0, cl8 = 1'b0;
  aes_blk_t   d8 = '0;
  logic       br8, rdy8, last8, ovf8;
  logic [7:0] o8;
  logic [1:0] lvl8;

  logic        v32 = 1'b0, rq32 = 1'b0, cl32 = 1'b0;
  aes_blk_t    d32 = '0;
  logic        br32, rdy32, last32, ovf32;
  logic [31:0] o32;
  logic [1:0]  lvl32;

  int total = 0;
  int bad   = 0;

  aes_blk_t mq[$];
  int       midx = 0;
  logic     movf = 1'b0;

  localparam aes_blk_t KBLK = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic [7:0]  kb [16] = '{8'h8e, 8'ha2, 8'hb7, 8'hca, 8'h51, 8'h67,
                           8'h45, 8'hbf, 8'hea, 8'hfc, 8'h49, 8'h90,
                           8'h4b, 8'h49, 8'h60, 8'h89};
  logic [31:0] kw [4]  = '{32'h4b496089, 32'heafc4990,
                           32'h516745bf, 32'h8ea2b7ca};
  vec8_t  kat8  [16];
  vec32_t kat32 [4];

  always #5 clk = ~clk;

  aes256_out_serializer #(
    .OUT_W(8), .DEPTH(2), .MSB_FIRST(1'b1)
  ) dut8 (
    .clk               (clk),
    .rst               (rst),
    .pi_blk_valid      (v8),
    .pi_blk_data       (d8),
    .po_blk_ready      (br8),
    .pi_next_val_req   (rq8),
    .po_next_val_ready (rdy8),
    .po_data           (o8),
    .po_last           (last8),
    .po_fifo_level     (lvl8),
    .po_overflow       (ovf8),
    .pi_clr_overflow   (cl8)
  );

  aes256_out_serializer #(
    .OUT_W(32), .DEPTH(2), .MSB_FIRST(1'b0)
  ) dut32 (
    .clk               (clk),
    .rst               (rst),
    .pi_blk_valid      (v32),
    .pi_blk_data       (d32),
    .po_blk_ready      (br32),
    .pi_next_val_req   (rq32),
    .po_next_val_ready (rdy32),
    .po_data           (o32),
    .po_last           (last32),
    .po_fifo_level     (lvl32),
    .po_overflow       (ovf32),
    .pi_clr_overflow   (cl32)
  );

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input aes_blk_t b, input int i);
    return b[127 - 8 * i -: 8];
  endfunction

  function automatic aes_blk_t rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One cycle on dut8 checked against the block-queue model.
  task automatic step8(input logic v, input aes_blk_t d,
                       input logic rq, input logic cl);
    logic m_rdy, m_last, m_br;
    logic [7:0] m_data;
    v8 = v; d8 = d; rq8 = rq; cl8 = cl;
    #1;
    m_rdy  = mq.size() != 0;
    m_last = m_rdy && midx == 15;
    m_data = m_rdy ? byte_of(mq[0], midx) : 8'h00;
    m_br   = mq.size() < 2 || (m_rdy && rq && m_last);
    chk("ready", rdy8, m_rdy);
    chk("last", last8, m_last);
    chk("data", o8, m_data);
    chk("level", lvl8, mq.size());
    chk("ovf", ovf8, movf);
    chk("blk_ready", br8, m_br);
    @(posedge clk); #1;
    if (m_rdy && rq) begin
      if (m_last) begin
        midx = 0;
        void'(mq.pop_front());
      end else begin
        midx++;
      end
    end
    if (v && m_br) mq.push_back(d);
    if (v && !m_br) movf = 1'b1;
    else if (cl)    movf = 1'b0;
  endtask

  task automatic drain8();
    for (int i = 0; i < 80 && mq.size() != 0; i++)
      step8(1'b0, '0, 1'b1, 1'b0);
    chk("drain_empty", lvl8, 2'd0);
  endtask

  initial begin
    aes_blk_t a, b, c;
    for (int i = 0; i < 16; i++) kat8[i] = '{kb[i], i == 15};
    for (int i = 0; i < 4; i++)  kat32[i] = '{kw[i], i == 3};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", rdy8, 1'b0);
    chk("rst_last", last8, 1'b0);
    chk("rst_data", o8, 8'h00);
    chk("rst_level", lvl8, 2'd0);
    chk("rst_ovf", ovf8, 1'b0);
    chk("rst_blk_ready", br8, 1'b1);
    chk("rst_ready32", rdy32, 1'b0);
    chk("rst_data32", o32, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Known-answer block on both widths
    v8 = 1'b1; d8 = KBLK; v32 = 1'b1; d32 = KBLK;
    @(posedge clk); #1;
    v8 = 1'b0; v32 = 1'b0; rq8 = 1'b1; rq32 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("kat8_ready", rdy8, 1'b1);
      chk("kat8_data", o8, kat8[i].data);
      chk("kat8_last", last8, kat8[i].last);
      if (i < 4) begin
        chk("kat32_data", o32, kat32[i].data);
        chk("kat32_last", last32, kat32[i].last);
      end
      @(posedge clk); #1;
    end
    rq8 = 1'b0; rq32 = 1'b0;
    #1;
    chk("kat8_done_ready", rdy8, 1'b0);
    chk("kat8_done_level", lvl8, 2'd0);
    chk("kat32_done_level", lvl32, 2'd0);

    // Backpressure: req 1,0,0,1,0,0,...
    step8(1'b1, KBLK, 1'b0, 1'b0);
    for (int i = 0; i < 60 && mq.size() != 0; i++)
      step8(1'b0, '0, (i % 3) == 0, 1'b0);
    chk("bp_empty", lvl8, 2'd0);

    // Overflow: fill with req=0, third block dropped
    a = rnd_blk(); b = rnd_blk(); c = rnd_blk();
    step8(1'b1, a, 1'b0, 1'b0);
    step8(1'b1, b, 1'b0, 1'b0);
    step8(1'b1, c, 1'b0, 1'b0);
    chk("ovf_set", ovf8, 1'b1);
    chk("ovf_level", lvl8, 2'd2);
    chk("ovf_head", o8, byte_of(a, 0));
    for (int i = 0; i < 16; i++) step8(1'b0, '0, 1'b1, 1'b0);
    chk("ovf_second", o8, byte_of(b, 0));
    drain8();
    step8(1'b0, '0, 1'b0, 1'b1);
    chk("ovf_clr", ovf8, 1'b0);

    // Full FIFO, push on the head's last-word transfer
    step8(1'b1, a, 1'b0, 1'b0);
    step8(1'b1, b, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step8(1'b0, '0, 1'b1, 1'b0);
    chk("full_last", last8, 1'b1);
    step8(1'b1, c, 1'b1, 1'b0);
    chk("full_push_level", lvl8, 2'd2);
    chk("full_push_ovf", ovf8, 1'b0);
    chk("full_push_head", o8, byte_of(b, 0));
    drain8();

    // Reset while streaming byte 5
    step8(1'b1, KBLK, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step8(1'b0, '0, 1'b1, 1'b0);
    chk("mid_byte5", o8, kb[5]);
    rq8 = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready", rdy8, 1'b0);
    chk("mid_rst_level", lvl8, 2'd0);
    chk("mid_rst_last", last8, 1'b0);
    rst = 1'b0;
    mq.delete(); midx = 0; movf = 1'b0;
    step8(1'b1, a, 1'b0, 1'b0);
    chk("mid_restart", o8, byte_of(a, 0));
    drain8();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++)
      step8($urandom_range(0, 9) < 2, rnd_blk(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    drain8();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
